// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_e;

  function automatic int offset_bits(input int line_length);
    return $clog2(line_length);
  endfunction

  // NSETS is expected to be at least 2 so the index field is never empty.
  function automatic int index_bits(input int nsets);
    return $clog2(nsets);
  endfunction

  function automatic int beat_bits(input int line_length, input int dw);
    return $clog2(line_length * 8 / dw);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: line data, tag and valid bit per set, filled one beat at a time.
module icache_way
  import icache_pkg::*;
#(
  parameter int LINE_BITS = 32,
  parameter int NSETS     = 4,
  parameter int TAG_W     = 18,
  parameter int DW        = 4,
  parameter int IDX_W     = index_bits(NSETS),
  parameter int BEAT_W    = $clog2(LINE_BITS / DW)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic [LINE_BITS-1:0] line_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 valid_o,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic                 beat_we_i,
  input  logic [BEAT_W-1:0]    beat_i,
  input  logic [DW-1:0]        beat_data_i,
  input  logic                 tag_we_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic                 inval_i,
  input  logic                 clear_all_i
);

  logic [NSETS-1:0]     valid_q;
  logic [LINE_BITS-1:0] data_q [NSETS];
  logic [TAG_W-1:0]     tag_q  [NSETS];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else begin
      if (inval_i)  valid_q[wr_idx_i] <= 1'b0;
      if (tag_we_i) valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (beat_we_i) data_q[wr_idx_i][beat_i*DW +: DW] <= beat_data_i;
    if (tag_we_i)  tag_q[wr_idx_i] <= tag_i;
  end

  assign line_o  = data_q[rd_idx_i];
  assign tag_o   = tag_q[rd_idx_i];
  assign valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with beat-wise line fill and LRU replacement.
// Define ICACHE_FLUSH_EN to add the flush port (invalidate all, abort fill).
module icache_assoc
  import icache_pkg::*;
#(
  parameter int LINE_LENGTH = 4,
  parameter int NSETS       = 4,
  parameter int WAYS        = 2,
  parameter int RV          = 16,
  parameter int PA          = 22,
  parameter int DW          = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [PA-1:0]                         paddr,
  input  logic                                  req,
  input  logic                                  fault,
  input  logic [DW-1:0]                         dread,
  input  logic                                  wstrobe_d,
`ifdef ICACHE_FLUSH_EN
  input  logic                                  flush,
`endif
  output logic                                  hit,
  output logic                                  pull,
  output logic [PA-offset_bits(LINE_LENGTH)-1:0] tag,
  output logic [RV-1:0]                         rdata,
  output logic                                  busy
);

  localparam int OFF_W     = offset_bits(LINE_LENGTH);
  localparam int IDX_W     = index_bits(NSETS);
  localparam int TAG_W     = PA - OFF_W - IDX_W;
  localparam int LINE_BITS = LINE_LENGTH * 8;
  localparam int BEAT_W    = beat_bits(LINE_LENGTH, DW);
  localparam int LAST_BEAT = LINE_BITS / DW - 1;
  localparam int RB_W      = $clog2(RV / 8);

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  assign req_idx = paddr[OFF_W +: IDX_W];
  assign req_tag = paddr[PA-1 -: TAG_W];

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0]  set_q, set_d;
  logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
  logic              vict_q, vict_d;

  logic [LINE_BITS-1:0] way_line [WAYS];
  logic [TAG_W-1:0]     way_tag  [WAYS];
  logic [WAYS-1:0]      way_valid, hit_vec;

  logic [IDX_W-1:0] wr_idx_c;
  logic beat_we_c, tag_we_c, inval_c, clear_all_c, lru_hit_c, lru_fill_c;
  logic victim_c, hit_way_c, flush_c;

`ifdef ICACHE_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .LINE_BITS(LINE_BITS), .NSETS(NSETS), .TAG_W(TAG_W), .DW(DW),
      .IDX_W(IDX_W), .BEAT_W(BEAT_W)
    ) u_way (
      .clk        (clk),
      .reset      (reset),
      .rd_idx_i   (req_idx),
      .line_o     (way_line[w]),
      .tag_o      (way_tag[w]),
      .valid_o    (way_valid[w]),
      .wr_idx_i   (wr_idx_c),
      .beat_we_i  (beat_we_c && (vict_q == 1'(w))),
      .beat_i     (beat_q),
      .beat_data_i(dread),
      .tag_we_i   (tag_we_c && (vict_q == 1'(w))),
      .tag_i      (fill_tag_q),
      .inval_i    (inval_c && (victim_c == 1'(w))),
      .clear_all_i(clear_all_c)
    );
    assign hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag) && (state_q == IDLE);
  end

  assign hit = |hit_vec;

  // lru_q[set] names the way to evict next in that set.
  if (WAYS == 2) begin : g_lru
    logic [NSETS-1:0] lru_q;
    always_ff @(posedge clk) begin
      if (reset)           lru_q <= '0;
      else if (lru_fill_c) lru_q[set_q] <= ~vict_q;
      else if (lru_hit_c)  lru_q[req_idx] <= ~hit_way_c;
    end
    assign hit_way_c = hit_vec[1];
    assign victim_c  = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[req_idx]);
  end else begin : g_no_lru
    assign hit_way_c = 1'b0;
    assign victim_c  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      set_q      <= '0;
      fill_tag_q <= '0;
      vict_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      set_q      <= set_d;
      fill_tag_q <= fill_tag_d;
      vict_q     <= vict_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    set_d       = set_q;
    fill_tag_d  = fill_tag_q;
    vict_d      = vict_q;
    wr_idx_c    = set_q;
    beat_we_c   = 1'b0;
    tag_we_c    = 1'b0;
    inval_c     = 1'b0;
    clear_all_c = 1'b0;
    lru_hit_c   = 1'b0;
    lru_fill_c  = 1'b0;
    if (flush_c) begin
      clear_all_c = 1'b1;
      state_d     = IDLE;
      beat_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && hit) begin
            lru_hit_c = 1'b1;
          end else if (req) begin
            state_d    = FILL;
            set_d      = req_idx;
            fill_tag_d = req_tag;
            vict_d     = victim_c;
            wr_idx_c   = req_idx;
            inval_c    = 1'b1;
            beat_d     = '0;
          end
        end
        FILL: begin
          // A fault discards the beat it arrives with, including the final one.
          if (fault) begin
            state_d = IDLE;
            beat_d  = '0;
          end else if (wstrobe_d) begin
            beat_we_c = 1'b1;
            if (beat_q == BEAT_W'(LAST_BEAT)) begin
              tag_we_c   = 1'b1;
              lru_fill_c = 1'b1;
              state_d    = DONE;
              beat_d     = '0;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign pull = (state_q == FILL);
  assign busy = (state_q != IDLE);
  assign tag  = {fill_tag_q, set_q};

  logic [OFF_W-1:0]     sel;
  logic [LINE_BITS-1:0] hit_line;
  logic [RV-1:0]        slice;
  assign sel = paddr[OFF_W-1:0] >> RB_W;

  // The lowest-addressed byte of the selected slice lands in the top byte of rdata.
  always_comb begin
    rdata    = 'x;
    hit_line = way_line[hit_way_c];
    slice    = RV'(hit_line >> (sel * RV));
    if (hit) begin
      for (int b = 0; b < RV / 8; b++) begin
        rdata[8*b +: 8] = slice[RV-8-8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed self-checking bench for icache_assoc at default parameters.
module tb_icache_assoc;

  localparam int PA = 22;

  logic          clk = 1'b0;
  logic          reset, req, fault, wstrobe_d;
  logic [PA-1:0] paddr;
  logic [3:0]    dread;
`ifdef ICACHE_FLUSH_EN
  logic          flush;
`endif
  logic          hit, pull, busy;
  logic [19:0]   tag;
  logic [15:0]   rdata;

  int total = 0;
  int bad   = 0;

  icache_assoc dut (
    .clk      (clk),
    .reset    (reset),
    .paddr    (paddr),
    .req      (req),
    .fault    (fault),
    .dread    (dread),
    .wstrobe_d(wstrobe_d),
`ifdef ICACHE_FLUSH_EN
    .flush    (flush),
`endif
    .hit      (hit),
    .pull     (pull),
    .tag      (tag),
    .rdata    (rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic probe(input logic [PA-1:0] a);
    paddr = a;
    #1;
  endtask

  task automatic start_miss(input logic [PA-1:0] a);
    paddr = a;
    req   = 1'b1;
    tick();
    req   = 1'b0;
  endtask

  task automatic beats(input logic [31:0] line, input int first, input int count);
    for (int n = first; n < first + count; n++) begin
      dread     = line[4*n +: 4];
      wstrobe_d = 1'b1;
      tick();
    end
    wstrobe_d = 1'b0;
  endtask

  task automatic fill(input logic [PA-1:0] a, input logic [31:0] line);
    start_miss(a);
    beats(line, 0, 8);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 1'b0; fault = 1'b0; wstrobe_d = 1'b0;
    dread = '0; paddr = 22'h10;
`ifdef ICACHE_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    tick();
    check("rst_pull", pull, 0);
    check("rst_busy", busy, 0);
    check("rst_hit", hit, 0);
    reset = 1'b0;

    // First fill: 0x10 -> set 0, line 0x87654321
    probe(22'h10);
    check("first_miss", hit, 0);
    start_miss(22'h10);
    check("fill_pull", pull, 1);
    check("fill_tag", tag, 20'h4);
    check("fill_busy", busy, 1);
    beats(32'h8765_4321, 0, 8);
    check("done_pull", pull, 0);
    check("done_busy", busy, 1);
    check("done_hit", hit, 0);
    tick();
    check("retry_hit", hit, 1);
    check("retry_rdata", rdata, 16'h2143);
    probe(22'h12);
    check("upper_rdata", rdata, 16'h6587);

    // LRU: A (way0), B (way1), touch A, C evicts B
    fill(22'h114, 32'h1234_ABCD);
    fill(22'h224, 32'h5566_7788);
    probe(22'h114);
    check("a_hit", hit, 1);
    req = 1'b1;
    tick();
    req = 1'b0;
    fill(22'h334, 32'h0F1E_2D3C);
    probe(22'h114);
    check("a_still_hit", hit, 1);
    check("a_rdata", rdata, 16'hCDAB);
    probe(22'h334);
    check("c_hit", hit, 1);
    check("c_rdata", rdata, 16'h3C2D);
    probe(22'h336);
    check("c_upper_rdata", rdata, 16'h1E0F);
    probe(22'h224);
    check("b_evicted", hit, 0);

    // Fault with final beat: victim (A, LRU way 0) invalid, F not valid
    start_miss(22'h444);
    beats(32'h1111_1111, 0, 7);
    fault = 1'b1; wstrobe_d = 1'b1; dread = 4'h1;
    tick();
    fault = 1'b0; wstrobe_d = 1'b0;
    check("fault_last_busy", busy, 0);
    probe(22'h444);
    check("f_not_valid", hit, 0);
    probe(22'h114);
    check("victim_a_gone", hit, 0);
    probe(22'h334);
    check("c_survives", hit, 1);

    // Fault after 3 beats, then a clean refill needing all 8 beats
    start_miss(22'h58);
    beats(32'hDEAD_BEEF, 0, 3);
    fault = 1'b1;
    tick();
    fault = 1'b0;
    check("fault_busy", busy, 0);
    check("fault_pull", pull, 0);
    probe(22'h58);
    check("d_miss", hit, 0);
    beats(32'hFFFF_FFFF, 0, 2);
    start_miss(22'h58);
    check("refill_pull", pull, 1);
    check("refill_tag", tag, 20'h16);
    beats(32'hDEAD_BEEF, 0, 7);
    check("beat7_pull", pull, 1);
    beats(32'hDEAD_BEEF, 7, 1);
    check("beat8_pull", pull, 0);
    check("beat8_busy", busy, 1);
    tick();
    probe(22'h58);
    check("d_hit", hit, 1);
    check("d_rdata", rdata, 16'hEFBE);

`ifdef ICACHE_FLUSH_EN
    start_miss(22'h70);
    beats(32'h2222_2222, 0, 5);
    flush = 1'b1; wstrobe_d = 1'b1; dread = 4'h2;
    tick();
    flush = 1'b0; wstrobe_d = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_pull", pull, 0);
    probe(22'h10);
    check("flush_miss_0", hit, 0);
    probe(22'h334);
    check("flush_miss_c", hit, 0);
    probe(22'h58);
    check("flush_miss_d", hit, 0);
    probe(22'h70);
    check("flush_miss_h", hit, 0);
`endif

    // Reset mid-fill
    start_miss(22'h68);
    beats(32'h3333_3333, 0, 4);
    reset = 1'b1;
    tick();
    check("midrst_pull", pull, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    probe(22'h10);
    check("rst_miss_0", hit, 0);
    probe(22'h334);
    check("rst_miss_c", hit, 0);
    probe(22'h58);
    check("rst_miss_d", hit, 0);
    probe(22'h68);
    check("rst_miss_g", hit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
